// File: rtl/pic_cmd_sequencer_if.sv
// CPU-side bus of the 8259A command sequencer: strobes and byte in, buffer direction and byte out.
// Combinational bundle only, with no latency and no backpressure (the CPU bus has no stall).
interface pic_cmd_sequencer_if;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] data_in;
    logic       buf_rd_n;
    logic       buf_wr_n;
    logic [7:0] data_out;

    modport master (
        output cs_n, rd_n, wr_n, a0, data_in,
        input  buf_rd_n, buf_wr_n, data_out
    );

    modport slave (
        input  cs_n, rd_n, wr_n, a0, data_in,
        output buf_rd_n, buf_wr_n, data_out
    );
endinterface

// File: rtl/pic_cmd_sequencer.sv
// 8259A ICW/OCW sequencer: commits a write on its trailing strobe edge; registered outputs lag strobes by 1 cycle.
// No backpressure. The optional poll command (OCW3 P bit) is built only when POLL_CMD_EN is defined.
module pic_cmd_sequencer #(
    parameter logic [7:0] IMR_INIT     = 8'h00,
    parameter bit         RESET_RD_ISR = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pic_cmd_sequencer_if.slave     bus,
    input  logic [7:0]             irr,
    input  logic [7:0]             isr,
    output logic [7:0]             icw1,
    output logic [7:0]             icw2,
    output logic [7:0]             icw3,
    output logic [7:0]             icw4,
    output logic [7:0]             imr,
    output logic [7:0]             ocw2,
    output logic                   ocw2_stb,
    output logic                   init_done,
    output logic [2:0]             seq_state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     state, nxt;
    logic       wr_q;
    logic [7:0] cap_d;
    logic       cap_a0;
    logic       rd_isr;
    logic       wr_act, rd_act, rd_eff, commit, is_icw1;
    logic [7:0] rd_mux;

    assign wr_act    = !bus.cs_n && !bus.wr_n;
    assign rd_act    = !bus.cs_n && !bus.rd_n;
    // A write wins over a simultaneous read.
    assign rd_eff    = rd_act && !wr_act;
    // The trailing edge includes cs_n rising while wr_n is still low.
    assign commit    = wr_q && !wr_act;
    assign is_icw1   = !cap_a0 && cap_d[4];
    assign seq_state = state;

    always_comb begin
        nxt = state;
        if (commit) begin
            if (is_icw1) begin
                nxt = WAIT_ICW2;
            end else if (cap_a0) begin
                case (state)
                    WAIT_ICW2: nxt = !icw1[1] ? WAIT_ICW3 : (icw1[0] ? WAIT_ICW4 : READY);
                    WAIT_ICW3: nxt = icw1[0] ? WAIT_ICW4 : READY;
                    WAIT_ICW4: nxt = READY;
                    default:   nxt = state;
                endcase
            end
        end
    end

`ifdef POLL_CMD_EN
    logic       poll;
    logic       rd_q;
    logic       rd_a0_q;
    logic [7:0] pend;
    logic [2:0] lvl;

    assign pend = irr & ~imr;

    // Scanning downward leaves the lowest set bit as the final winner.
    always_comb begin
        lvl = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) lvl = 3'(i);
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (bus.a0)      rd_mux = imr;
        else if (poll)   rd_mux = {|irr, 4'b0000, lvl};
        else if (rd_isr) rd_mux = isr;
        else             rd_mux = irr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll    <= 1'b0;
            rd_q    <= 1'b0;
            rd_a0_q <= 1'b0;
        end else begin
            rd_q <= rd_eff;
            if (rd_eff) rd_a0_q <= bus.a0;
            if (commit && is_icw1) begin
                poll <= 1'b0;
            end else if (commit && state == READY && !cap_a0 && cap_d[4:3] == 2'b01 && cap_d[2]) begin
                poll <= 1'b1;
            end else if (rd_q && !rd_eff && !rd_a0_q) begin
                poll <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        rd_mux = 8'h00;
        if (bus.a0)      rd_mux = imr;
        else if (rd_isr) rd_mux = isr;
        else             rd_mux = irr;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_q         <= 1'b0;
            cap_d        <= 8'h00;
            cap_a0       <= 1'b0;
            icw1         <= 8'h00;
            icw2         <= 8'h00;
            icw3         <= 8'h00;
            icw4         <= 8'h00;
            ocw2         <= 8'h00;
            imr          <= IMR_INIT;
            rd_isr       <= RESET_RD_ISR;
            ocw2_stb     <= 1'b0;
            init_done    <= 1'b0;
            bus.buf_rd_n <= 1'b1;
            bus.buf_wr_n <= 1'b1;
            bus.data_out <= 8'h00;
        end else begin
            state        <= nxt;
            init_done    <= (nxt == READY);
            wr_q         <= wr_act;
            bus.buf_wr_n <= !wr_act;
            bus.buf_rd_n <= !rd_eff;
            ocw2_stb     <= 1'b0;
            if (wr_act) begin
                cap_d  <= bus.data_in;
                cap_a0 <= bus.a0;
            end
            if (rd_eff) bus.data_out <= rd_mux;
            if (commit) begin
                if (is_icw1) begin
                    icw1   <= cap_d;
                    imr    <= IMR_INIT;
                    rd_isr <= 1'b0;
                    if (!cap_d[0]) icw4 <= 8'h00;
                end else begin
                    case (state)
                        WAIT_ICW2: if (cap_a0) icw2 <= cap_d;
                        WAIT_ICW3: if (cap_a0) icw3 <= cap_d;
                        WAIT_ICW4: if (cap_a0) icw4 <= cap_d;
                        READY: begin
                            if (cap_a0) begin
                                imr <= cap_d;
                            end else if (cap_d[4:3] == 2'b00) begin
                                ocw2     <= cap_d;
                                ocw2_stb <= 1'b1;
                            end else if (cap_d[4:3] == 2'b01 && cap_d[1]) begin
                                rd_isr <= cap_d[0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/pic_cmd_sequencer.md
Name: pic_cmd_sequencer

Overview:
Command and initialization sequencer for the 8259A PIC. It watches the CPU-side strobes (cs_n, rd_n, wr_n, a0) and drives the direction controls of the data bus buffer. Bytes written through the buffer are decoded into the ICW1–ICW4 initialization sequence and OCW1–OCW3 operation commands. It holds the resulting configuration registers and selects which status byte (IRR/ISR/IMR) the buffer returns on reads.

Parameters:
IMR_INIT, 8'h00, value loaded into the mask register (OCW1) on every ICW1 write.
RESET_RD_ISR, 0, reset value of the read-register select (0 = IRR, 1 = ISR).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cs_n  input  1  chip select, active low; already synchronous to clk.
rd_n  input  1  CPU read strobe, active low.
wr_n  input  1  CPU write strobe, active low.
a0  input  1  CPU address bit 0.
data_in  input  8  byte from the buffer's inside port.
irr  input  8  interrupt request register value.
isr  input  8  in-service register value.
buf_rd_n  output  1  to buffer rd; low = buffer drives CPU bus.
buf_wr_n  output  1  to buffer wr; low = buffer passes CPU byte inward.
data_out  output  8  byte presented to the buffer during reads.
icw1  output  8  latched ICW1.
icw2  output  8  latched ICW2 (vector base in [7:3]).
icw3  output  8  latched ICW3.
icw4  output  8  latched ICW4.
imr  output  8  interrupt mask (OCW1).
ocw2  output  8  last OCW2 byte.
ocw2_stb  output  1  one-cycle pulse when OCW2 is committed.
init_done  output  1  high in READY state.
seq_state  output  3  current FSM state encoding.

Behaviour:
- Qualified strobes: wr_act = !cs_n & !wr_n; rd_act = !cs_n & !rd_n.
- buf_wr_n = !wr_act and buf_rd_n = !rd_act. Both are registered, so there is 1 cycle of latency after the strobe.
- Write capture: while wr_act is high, data_in and a0 are latched every cycle. The last latched value is used.
- Write commit: on the clock edge where registered wr_act was 1 and the current wr_act is 0 (trailing edge). Committed registers are visible on the next cycle.
- FSM states: IDLE=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4.
- Reset: state IDLE. icw1..icw4 = 0, ocw2 = 0, imr = IMR_INIT, rd_isr = RESET_RD_ISR. buf_rd_n = 1, buf_wr_n = 1, ocw2_stb = 0, init_done = 0, data_out = 0.
- ICW1 (a0=0, d[4]=1), accepted in any state:
  - icw1 <= d; imr <= IMR_INIT; rd_isr <= 0.
  - icw2, icw3 and icw4 are kept; icw4 is cleared to 0 if d[0]=0.
  - Next state WAIT_ICW2. An ICW1 arriving mid-sequence restarts the sequence.
- WAIT_ICW2, a0=1:
  - icw2 <= d.
  - Next state: WAIT_ICW3 if icw1[1]=0 (cascade); else WAIT_ICW4 if icw1[0]=1; else READY.
- WAIT_ICW3, a0=1: icw3 <= d. Next state WAIT_ICW4 if icw1[0]=1, else READY.
- WAIT_ICW4, a0=1: icw4 <= d. Next state READY.
- Writes with a0=0 that are not ICW1, in any WAIT state: ignored; state unchanged.
- READY, a0=1: imr <= d (OCW1).
- READY, a0=0, d[4:3]=00: ocw2 <= d; ocw2_stb high for exactly 1 cycle (OCW2).
- READY, a0=0, d[4:3]=01 (OCW3): if d[1]=1 then rd_isr <= d[0]; if d[1]=0, rd_isr is unchanged.
- IDLE: every write except ICW1 is ignored.
- Read mux (registered, updated every cycle while rd_act):
  - a0=1: data_out = imr.
  - a0=0: data_out = isr if rd_isr, else irr.
  - When not reading, data_out holds its value.
- Simultaneous wr_act and rd_act: the write has priority. buf_rd_n stays 1 and the read mux is not updated.
- cs_n rising during a write counts as the trailing edge and commits the write.
- An asynchronous reset asserted mid-write discards the captured byte.

Optional Feature:
POLL_CMD_EN
- Defined:
  - An OCW3 with d[2]=1 arms a poll flag.
  - The next read with a0=0 returns {1'b?, 4'b0, lvl[2:0]}. Bit 7 = |irr and lvl = index of the lowest set bit of irr & ~imr.
  - The poll flag clears on that read's trailing edge.
- Undefined: OCW3 d[2] is ignored and no poll logic is synthesized.

Test Plan:
- Reset, then write ICW1=8'h13 (single, IC4), ICW2=8'h20, ICW4=8'h01 -> icw2=8'h20, icw4=8'h01, icw3=0, init_done=1 one cycle after the third commit.
- ICW1=8'h11 (cascade), ICW2=8'h40, ICW3=8'h04, ICW4=8'h01 -> state goes 1,2,3,4; icw3=8'h04.
- In READY, write a0=1 8'hA5, then read a0=1 -> imr=8'hA5; buf_rd_n=0 one cycle after rd_act; data_out=8'hA5.
- irr=8'h0C, isr=8'h02: OCW3=8'h0B then read a0=0 gives 8'h02; OCW3=8'h0A then read gives 8'h0C. OCW2=8'h20 gives ocw2_stb=1 for exactly one cycle.
- After ICW2 in a cascade sequence, write ICW1=8'h13 -> state=1 and imr=IMR_INIT; the following a0=1 write lands in icw2.
- Assert rst_n=0 during a write of 8'hFF with a0=1 in READY -> imr returns to IMR_INIT and no commit occurs after release.
